// File: rtl/tx_arp_pack.sv
// tx_arp_pack: builds 28-byte ARP replies (from ack_en + get_mac_pc) and ARP
// requests (from req_en) and streams them as seven 32-bit big-endian words
// with sop/eop/vld framing and tx_rdy back-pressure.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   cfg_mac_local/ip_local     sender MAC / IP
//   cfg_ip_pc                  target IP
//   ack_en, get_mac_pc         reply trigger with the PC MAC (same cycle)
//   req_en                     request trigger
//   tx_rdy                     downstream ready
//   tx_data/vld/sop/eop/mod    payload stream (mod is always 0)
//   tx_dst_mac                 Ethernet destination for the current packet
//   busy                       packet in flight or pending
module tx_arp_pack #(
    parameter int unsigned MAC_ADDR_W = 48,
    parameter int unsigned IP_ADDR_W  = 32,
    parameter int unsigned DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [MAC_ADDR_W-1:0] cfg_mac_local,
    input  logic [IP_ADDR_W-1:0]  cfg_ip_local,
    input  logic [IP_ADDR_W-1:0]  cfg_ip_pc,
    input  logic                  ack_en,
    input  logic [MAC_ADDR_W-1:0] get_mac_pc,
    input  logic                  req_en,
    input  logic                  tx_rdy,
    output logic [DATA_W-1:0]     tx_data,
    output logic                  tx_vld,
    output logic                  tx_sop,
    output logic                  tx_eop,
    output logic [1:0]            tx_mod,
    output logic [MAC_ADDR_W-1:0] tx_dst_mac,
    output logic                  busy
);

    localparam int unsigned CNT_W = 3;
    localparam logic [CNT_W-1:0] LAST_IDX = 3'd6;
    localparam logic [15:0] OP_REPLY   = 16'h0002;
    localparam logic [15:0] OP_REQUEST = 16'h0001;

    // LOAD is the one-cycle slot between launch and W0 appearing on the bus.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2
    } state_t;

    state_t                state;
    state_t                state_d;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      nidx;
    logic                  ack_pend;
    logic                  req_pend;
    logic                  ack_pend_d;
    logic                  req_pend_d;
    logic                  busy_d;
    logic [MAC_ADDR_W-1:0] pend_mac;
    logic [MAC_ADDR_W-1:0] pend_mac_d;
    logic [MAC_ADDR_W-1:0] launch_mac;
    logic                  launch_ack;
    logic                  launch_req;
    logic                  accept;
    logic                  last_accept;

    // packet snapshot, immune to configuration changes mid-packet
    logic [MAC_ADDR_W-1:0] pkt_sm;
    logic [IP_ADDR_W-1:0]  pkt_si;
    logic [IP_ADDR_W-1:0]  pkt_ti;
    logic [MAC_ADDR_W-1:0] pkt_tm;
    logic                  pkt_reply;
    logic [DATA_W-1:0]     word_c;

    // launch decode and next pending-flag / state values
    always_comb begin
        launch_ack  = 1'b0;
        launch_req  = 1'b0;
        state_d     = state;
        accept      = tx_vld && tx_rdy;
        last_accept = 1'b0;

        if (state == IDLE) begin
            launch_ack = ack_pend || ack_en;
            launch_req = !launch_ack && (req_pend || req_en);
        end

        // a trigger only survives a launch of its own type if one was already pending
        ack_pend_d = launch_ack ? (ack_pend && ack_en) : (ack_pend || ack_en);
        req_pend_d = launch_req ? (req_pend && req_en) : (req_pend || req_en);
        pend_mac_d = ack_en ? get_mac_pc : pend_mac;
        launch_mac = ack_pend ? pend_mac : get_mac_pc;

        case (state)
            IDLE: if (launch_ack || launch_req) state_d = LOAD;
            LOAD: state_d = SEND;
            SEND: begin
                last_accept = accept && (cnt == LAST_IDX);
                if (last_accept) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE) || ack_pend_d || req_pend_d;
    end

    // word to be presented next: W0 from LOAD, otherwise the one after cnt
    assign nidx = (state == LOAD) ? '0 : cnt + 3'd1;

    always_comb begin
        case (nidx)
            3'd0:    word_c = 32'h0001_0800;
            3'd1:    word_c = {8'h06, 8'h04, (pkt_reply ? OP_REPLY : OP_REQUEST)};
            3'd2:    word_c = pkt_sm[47:16];
            3'd3:    word_c = {pkt_sm[15:0], pkt_si[31:16]};
            3'd4:    word_c = {pkt_si[15:0], pkt_tm[47:32]};
            3'd5:    word_c = pkt_tm[31:0];
            default: word_c = pkt_ti;
        endcase
    end

    // state, pending flags, packet snapshot and registered stream outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            ack_pend   <= 1'b0;
            req_pend   <= 1'b0;
            pend_mac   <= '0;
            busy       <= 1'b0;
            pkt_sm     <= '0;
            pkt_si     <= '0;
            pkt_ti     <= '0;
            pkt_tm     <= '0;
            pkt_reply  <= 1'b0;
            tx_data    <= '0;
            tx_vld     <= 1'b0;
            tx_sop     <= 1'b0;
            tx_eop     <= 1'b0;
            tx_mod     <= 2'b00;
            tx_dst_mac <= '0;
        end else begin
            state    <= state_d;
            ack_pend <= ack_pend_d;
            req_pend <= req_pend_d;
            pend_mac <= pend_mac_d;
            busy     <= busy_d;
            tx_mod   <= 2'b00;

            if (launch_ack || launch_req) begin
                pkt_sm    <= cfg_mac_local;
                pkt_si    <= cfg_ip_local;
                pkt_ti    <= cfg_ip_pc;
                pkt_reply <= launch_ack;
                pkt_tm    <= launch_ack ? launch_mac : '0;
            end

            case (state)
                LOAD: begin
                    tx_data    <= word_c;
                    tx_vld     <= 1'b1;
                    tx_sop     <= 1'b1;
                    tx_eop     <= 1'b0;
                    cnt        <= '0;
                    tx_dst_mac <= pkt_reply ? pkt_tm : '1;
                end
                SEND: begin
                    if (accept) begin
                        if (cnt == LAST_IDX) begin
                            tx_vld <= 1'b0;
                            tx_sop <= 1'b0;
                            tx_eop <= 1'b0;
                            cnt    <= '0;
                        end else begin
                            tx_data <= word_c;
                            tx_sop  <= 1'b0;
                            tx_eop  <= (cnt == LAST_IDX - 3'd1);
                            cnt     <= cnt + 3'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
